// File: rtl/tape_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tape_decoder
// Description : EAR-input tape decoder. Measures edge-to-edge half periods,
//               recognises pilot, sync and bit pulses, assembles LSB-first
//               bytes and writes them sequentially into the tape RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_decoder #(
    parameter int CLK_FREQ         = 27000000,
    parameter int BIT0_PERIOD      = CLK_FREQ / 480,
    parameter int BIT1_PERIOD      = CLK_FREQ / 240,
    parameter int MIN_PILOT_HALVES = 256,
    parameter int TIMEOUT_MS       = 500,
    parameter int ADDR_W           = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rec_start,
    input  logic              ear_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              loading,
    output logic              block_done,
    output logic [ADDR_W:0]   byte_count,
    output logic              err,
    output logic              full
);

    // Classification windows and silence limit, in clock cycles
    localparam logic [23:0] c_thresh   = 24'((BIT0_PERIOD + BIT1_PERIOD) / 2);
    localparam logic [23:0] c_min_half = 24'(BIT0_PERIOD / 2);
    localparam logic [23:0] c_max_half = 24'(BIT1_PERIOD + BIT1_PERIOD / 2);
    localparam logic [23:0] c_timeout  = 24'((CLK_FREQ / 1000) * TIMEOUT_MS);
    localparam logic [15:0] c_min_pilot = 16'(MIN_PILOT_HALVES);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pilot = 2'd1;
    localparam logic [1:0] c_st_sync  = 2'd2;
    localparam logic [1:0] c_st_data  = 2'd3;

    logic              r_ear_s1;
    logic              r_ear_s2;
    logic              r_ear_d;
    logic [23:0]       r_hp_cnt;
    logic [1:0]        r_state;
    logic [15:0]       r_pilot_cnt;
    logic [2:0]        r_bit_idx;
    logic              r_half;
    logic              r_first_long;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_block_done;
    logic [ADDR_W:0]   r_byte_count;
    logic              r_err;
    logic              r_full;

    logic              w_edge;
    logic              w_short;
    logic              w_long;
    logic              w_timeout;
    logic              w_last_addr;
    logic [7:0]        w_new_shift;

    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ear_s1 <= 1'b0;
            r_ear_s2 <= 1'b0;
            r_ear_d  <= 1'b0;
        end else begin
            r_ear_s1 <= ear_in;
            r_ear_s2 <= r_ear_s1;
            r_ear_d  <= r_ear_s2;
        end
    end

    assign w_edge      = r_ear_s2 ^ r_ear_d;
    assign w_short     = (r_hp_cnt >= c_min_half) && (r_hp_cnt < c_thresh);
    assign w_long      = (r_hp_cnt >= c_thresh) && (r_hp_cnt <= c_max_half);
    assign w_timeout   = (r_hp_cnt == c_timeout);
    assign w_last_addr = (r_addr == {ADDR_W{1'b1}});

    // Shift register with the bit being completed inserted at its position
    always_comb begin
        w_new_shift            = r_shift;
        w_new_shift[r_bit_idx] = w_long;
    end

    // Half-period counter: restarts at 1 on each edge, saturates when silent
    always_ff @(posedge clk) begin
        if (reset || rec_start || !enable) begin
            r_hp_cnt <= 24'd0;
        end else if (w_edge) begin
            r_hp_cnt <= 24'd1;
        end else if (r_hp_cnt != 24'hFF_FFFF) begin
            r_hp_cnt <= r_hp_cnt + 24'd1;
        end
    end

    // Decoder state machine, byte assembly, RAM writes and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_pilot_cnt  <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_half       <= 1'b0;
            r_first_long <= 1'b0;
            r_shift      <= 8'd0;
            r_addr       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 8'd0;
            r_block_done <= 1'b0;
            r_byte_count <= '0;
            r_err        <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_block_done <= 1'b0;
            if (rec_start) begin
                r_state      <= c_st_idle;
                r_addr       <= '0;
                r_wr_addr    <= '0;
                r_byte_count <= '0;
                r_err        <= 1'b0;
                r_full       <= 1'b0;
            end else if (!enable || r_full) begin
                // Disarmed, or RAM exhausted: ignore the tape until re-armed
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_edge) begin
                            r_state     <= c_st_pilot;
                            r_pilot_cnt <= 16'd0;
                        end
                    end
                    c_st_pilot: begin
                        if (w_edge) begin
                            if (w_long) begin
                                if (r_pilot_cnt != 16'hFFFF) begin
                                    r_pilot_cnt <= r_pilot_cnt + 16'd1;
                                end
                            end else if (w_short && (r_pilot_cnt >= c_min_pilot)) begin
                                r_state <= c_st_sync;
                            end else begin
                                r_pilot_cnt <= 16'd0;
                            end
                        end else if (w_timeout) begin
                            r_state <= c_st_idle;
                        end
                    end
                    c_st_sync: begin
                        if (w_edge) begin
                            if (w_short) begin
                                r_state      <= c_st_data;
                                r_bit_idx    <= 3'd0;
                                r_half       <= 1'b0;
                                r_byte_count <= '0;
                            end else if (w_long) begin
                                r_state     <= c_st_pilot;
                                r_pilot_cnt <= 16'd1;
                            end else begin
                                r_state     <= c_st_pilot;
                                r_pilot_cnt <= 16'd0;
                            end
                        end else if (w_timeout) begin
                            r_state <= c_st_idle;
                        end
                    end
                    default: begin
                        if (w_edge) begin
                            if (!w_short && !w_long) begin
                                r_err        <= 1'b1;
                                r_state      <= c_st_idle;
                                r_block_done <= (r_byte_count != '0);
                            end else if (!r_half) begin
                                r_half       <= 1'b1;
                                r_first_long <= w_long;
                            end else if (r_first_long != w_long) begin
                                r_err        <= 1'b1;
                                r_state      <= c_st_idle;
                                r_block_done <= (r_byte_count != '0);
                            end else begin
                                r_half  <= 1'b0;
                                r_shift <= w_new_shift;
                                if (r_bit_idx == 3'd7) begin
                                    r_bit_idx    <= 3'd0;
                                    r_wr_en      <= 1'b1;
                                    r_wr_data    <= w_new_shift;
                                    r_wr_addr    <= r_addr;
                                    r_byte_count <= r_byte_count + (ADDR_W+1)'(1);
                                    if (w_last_addr) begin
                                        // Top of RAM reached: close the block
                                        r_full       <= 1'b1;
                                        r_state      <= c_st_idle;
                                        r_block_done <= 1'b1;
                                    end else begin
                                        r_addr <= r_addr + ADDR_W'(1);
                                    end
                                end else begin
                                    r_bit_idx <= r_bit_idx + 3'd1;
                                end
                            end
                        end else if (w_timeout) begin
                            r_state      <= c_st_idle;
                            r_block_done <= (r_byte_count != '0);
                        end
                    end
                endcase
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign loading    = (r_state == c_st_sync) || (r_state == c_st_data);
    assign block_done = r_block_done;
    assign byte_count = r_byte_count;
    assign err        = r_err;
    assign full       = r_full;

endmodule
`default_nettype wire

// File: tb/tb_tape_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tape_decoder
// Description : Randomized scoreboard bench for tape_decoder. A byte-level
//               tape model predicts RAM writes; a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_decoder;

    localparam int CLK_FREQ  = 48000;
    localparam int MIN_PILOT = 8;
    localparam int AW        = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          rec_start;
    logic          ear_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          loading;
    logic          block_done;
    logic [AW:0]   byte_count;
    logic          err;
    logic          full;

    always #5 clk = ~clk;

    tape_decoder #(
        .CLK_FREQ         (CLK_FREQ),
        .BIT0_PERIOD      (100),
        .BIT1_PERIOD      (200),
        .MIN_PILOT_HALVES (MIN_PILOT),
        .TIMEOUT_MS       (20),
        .ADDR_W           (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rec_start  (rec_start),
        .ear_in     (ear_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .loading    (loading),
        .block_done (block_done),
        .byte_count (byte_count),
        .err        (err),
        .full       (full)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  blk[0:16];
    int          cyc = 0;
    int          bd_count = 0;
    int          bd_cycle = 0;
    int          last_edge_cyc = 0;
    bit          saw_loading = 1'b0;

    // Byte-level tape model state
    int m_addr = 0;
    bit m_full = 1'b0;
    int m_bc   = 0;
    int m_bd   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on each write, tracks pulses and loading
    initial begin
        logic [11:0] e;
        logic prev_wr = 1'b0;
        logic prev_bd = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (loading) saw_loading = 1'b1;
            if (block_done) begin
                bd_count++;
                bd_cycle = cyc;
                check("block_done_width", prev_bd, 0);
            end
            if (wr_en) begin
                check("wr_en_width", prev_wr, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", wr_addr, 255);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e[11:8]);
                    check("wr_data", wr_data, e[7:0]);
                end
            end
            prev_wr = wr_en;
            prev_bd = block_done;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_total);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic half(input int n);
        wait_cyc(n);
        ear_in = ~ear_in;
    endtask

    function automatic int rshort();
        return $urandom_range(107, 95);
    endfunction

    function automatic int rlong();
        return $urandom_range(212, 190);
    endfunction

    task automatic send_bit(input logic b);
        half(b ? rlong() : rshort());
        half(b ? rlong() : rshort());
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    // Leading edge, pilot slots (one optionally replaced by a glitch), sync pair
    task automatic drive_lead(input int pilot, input int glitch_pos);
        ear_in = ~ear_in;
        for (int s = 1; s <= pilot; s++) begin
            if (s == glitch_pos) begin
                half(100);
                half(10);
                half(90);
            end else begin
                half(rlong());
            end
        end
        half(rshort());
        half(rshort());
    endtask

    // A block is captured only with enough uninterrupted pilot and free RAM
    task automatic model_block(input int eff_pilot, input int nb);
        int written;
        if (!enable || m_full || eff_pilot < MIN_PILOT) return;
        written = 0;
        for (int i = 0; i < nb; i++) begin
            if (!m_full) begin
                exp_q.push_back({4'(m_addr), blk[i]});
                m_addr++;
                written++;
                if (m_addr == (1 << AW)) m_full = 1'b1;
            end
        end
        m_bc = written;
        if (written > 0) m_bd++;
    endtask

    task automatic run_block(input int pilot, input int glitch_pos, input int nb, input int tail);
        model_block((glitch_pos > 0) ? pilot - glitch_pos : pilot, nb);
        drive_lead(pilot, glitch_pos);
        for (int i = 0; i < nb; i++) send_byte(blk[i]);
        last_edge_cyc = cyc;
        wait_cyc(tail);
    endtask

    task automatic pulse_rec_start();
        @(negedge clk);
        rec_start = 1'b1;
        @(negedge clk);
        rec_start = 1'b0;
        m_addr = 0;
        m_full = 1'b0;
        m_bc   = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_loading"}, loading, 0);
        check({tag, "_block_done"}, block_done, 0);
        check({tag, "_byte_count"}, byte_count, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_full"}, full, 0);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        rec_start = 1'b0;
        ear_in    = 1'b0;
        wait_cyc(4);
        check_reset_values("reset");
        reset = 1'b0;
        wait_cyc(2);

        // Single block: pilot, sync, 0xA5, silence
        blk[0] = 8'hA5;
        run_block(10, 0, 1, 1000);
        check("t1_block_done_count", bd_count, m_bd);
        check("t1_byte_count", byte_count, m_bc);
        check("t1_pending_writes", exp_q.size(), 0);
        check("t1_block_done_latency_ok",
              ((bd_cycle - last_edge_cyc) >= 950) && ((bd_cycle - last_edge_cyc) <= 980), 1);

        // Two back-to-back blocks land contiguously
        pulse_rec_start();
        for (int i = 0; i < 3; i++) blk[i] = 8'($urandom);
        run_block($urandom_range(9, 8), 0, 2, 1000);
        for (int i = 0; i < 3; i++) blk[i] = 8'($urandom);
        run_block($urandom_range(9, 8), 0, 3, 1000);
        check("t2_block_done_count", bd_count, m_bd);
        check("t2_byte_count", byte_count, m_bc);
        check("t2_pending_writes", exp_q.size(), 0);

        // Disarmed decoder ignores a full block and keeps its status
        enable = 1'b0;
        saw_loading = 1'b0;
        blk[0] = 8'($urandom);
        run_block(10, 0, 1, 1000);
        check("en_loading_seen", saw_loading, 0);
        check("en_byte_count_kept", byte_count, m_bc);
        check("en_wr_addr_kept", wr_addr, m_addr - 1);
        check("en_pending_writes", exp_q.size(), 0);
        enable = 1'b1;
        wait_cyc(2);

        // Too little pilot: never syncs
        pulse_rec_start();
        saw_loading = 1'b0;
        blk[0] = 8'hA5;
        run_block(5, 0, 1, 1000);
        check("short_loading_seen", saw_loading, 0);
        check("short_block_done_count", bd_count, m_bd);
        check("short_pending_writes", exp_q.size(), 0);

        // Mismatched half pair in DATA
        pulse_rec_start();
        drive_lead(10, 0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        half(rshort());
        half(rlong());
        wait_cyc(6);
        check("mis_err", err, 1);
        check("mis_loading", loading, 0);
        check("mis_byte_count", byte_count, 0);
        wait_cyc(1000);
        check("mis_block_done_count", bd_count, m_bd);
        check("mis_pending_writes", exp_q.size(), 0);

        // Glitch inside pilot restarts the pilot count
        pulse_rec_start();
        check("rec_clears_err", err, 0);
        saw_loading = 1'b0;
        blk[0] = 8'hA5;
        run_block(12, 6, 1, 1000);
        check("glitch_loading_seen", saw_loading, 0);
        check("glitch_pending_writes", exp_q.size(), 0);

        // Overflow: 17 bytes into a 16-entry RAM
        pulse_rec_start();
        for (int i = 0; i < 17; i++)
            blk[i] = $urandom_range(1, 0) ? (8'h01 << $urandom_range(7, 0)) : 8'h00;
        run_block(8, 0, 17, 1000);
        check("ovf_full", full, 1);
        check("ovf_byte_count", byte_count, m_bc);
        check("ovf_wr_addr", wr_addr, (1 << AW) - 1);
        check("ovf_block_done_count", bd_count, m_bd);
        check("ovf_pending_writes", exp_q.size(), 0);
        pulse_rec_start();
        wait_cyc(1);
        check("rec_clears_full", full, 0);
        check("rec_clears_wr_addr", wr_addr, 0);
        check("rec_clears_byte_count", byte_count, 0);

        // Reset in the middle of a byte
        drive_lead(10, 0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        wait_cyc(20);
        check("mid_loading_before_reset", loading, 1);
        reset = 1'b1;
        wait_cyc(1);
        check_reset_values("midreset");
        reset = 1'b0;
        wait_cyc(1000);
        check("mid_block_done_count", bd_count, m_bd);
        check("final_pending_writes", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
